seq_num_checker: RTL
====================

Name: seq_num_checker

Overview:
- Receive-side counterpart of the outgoing sequence-number path.
- Consumes the ASCII value of an incoming MsgSeqNum (tag 34) field byte-serially from the received-message parser.
- Converts the field to 32-bit binary and compares it against the expected sequence number for the sending host.
- Reports OK / GAP / LOW / format-error status, plus the binary value, to the session manager. The session manager uses the value for counter resync.

Parameters:
- BIN_WIDTH, 32, width of the binary sequence number and the expected value.
- MAX_DIGITS, 10, maximum accepted ASCII digits; one more digit is an overflow error.
- DCNT_WIDTH, 4, width of the digit counter and digits_o.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start_i  in  1  pulse; begins a new field and captures expected_seq_num_i.
- expected_seq_num_i  in  BIN_WIDTH  expected sequence number for the sender.
- byte_valid_i  in  1  byte_i is valid this cycle.
- byte_i  in  8  field byte: ASCII digit or SOH (0x01) terminator.
- byte_last_i  in  1  with byte_valid_i: this byte is the final byte of the field.
- byte_ready_o  out  1  block accepts a byte this cycle.
- seq_num_o  out  BIN_WIDTH  decoded binary value.
- seq_status_o  out  2  status code, see package.
- digits_o  out  DCNT_WIDTH  number of digits decoded.
- result_valid_o  out  1  result outputs are valid.
- result_ack_i  in  1  consumer acknowledges the result.

Behaviour:
- Reset values: byte_ready_o=0, result_valid_o=0, seq_num_o=0, seq_status_o=SEQ_OK, digits_o=0, FSM=IDLE. All other registers are also cleared.
- A byte transfers when byte_valid_i && byte_ready_o are both high. byte_ready_o=1 only in ACCUM and DRAIN.
- IDLE:
  - start_i: capture expected_seq_num_i, clear acc/count/err, go to ACCUM.
  - Bytes offered in IDLE are not accepted (ready=0).
- ACCUM, per accepted byte:
  - Digit 0x30-0x39: acc <= acc*10 + (byte-0x30). Compute as (acc<<3)+(acc<<1)+d in a BIN_WIDTH+4 bit intermediate. count <= count+1.
  - Overflow: if the intermediate exceeds 2^BIN_WIDTH-1, or count would exceed MAX_DIGITS, set err. If the byte is not the last, go to DRAIN.
  - SOH byte: terminates the field and is not a digit.
  - Any other byte: set err; go to DRAIN unless last.
  - byte_last_i on a digit also terminates the field, with that digit included.
  - On termination go to COMPARE.
- DRAIN: accept and discard bytes until SOH or byte_last_i, then go to COMPARE. err stays set.
- COMPARE (1 cycle), in priority order:
  - SEQ_ERR if err, count==0, value==0, or a leading-zero violation (see Optional Feature).
  - else SEQ_OK if value == expected.
  - else SEQ_GAP if value > expected.
  - else SEQ_LOW.
  - Load seq_num_o (truncated acc on error), digits_o and seq_status_o. Set result_valid_o. Go to RESULT.
- Latency: terminating byte accepted in cycle N, result_valid_o=1 in cycle N+2.
- RESULT:
  - Outputs are held stable until result_ack_i. Ack in the same cycle result_valid_o rises is legal.
  - On ack: result_valid_o <= 0 next cycle, go to IDLE.
  - start_i in RESULT is ignored and is the source's error.
- start_i in ACCUM or DRAIN aborts the current field and restarts: new expected value, acc/count/err cleared. No result is produced for the aborted field.
- Simultaneous start_i and a byte in ACCUM: start_i wins and the byte is not consumed. byte_ready_o is a registered state decode; the data source must hold a byte that was not accepted.
- Reset asserted mid-operation: immediate return to IDLE with all outputs at reset values. No partial result is produced.
- Comparison is unsigned. Expected value wrap-around is not handled here.

Optional Feature:
- Macro: SEQ_LEADING_ZERO_EN.
- Defined: leading '0' digits are accepted and contribute nothing to acc; they still count toward MAX_DIGITS.
- Undefined (default, strict FIX): a '0' as first digit of a multi-digit field forces SEQ_ERR. The field "0" alone is already SEQ_ERR because value==0.

Decomposition:
- Shared package seq_pkg holds:
  - Status codes: SEQ_OK=2'b00, SEQ_GAP=2'b01, SEQ_LOW=2'b10, SEQ_ERR=2'b11.
  - FSM state encoding: IDLE, ACCUM, DRAIN, COMPARE, RESULT.
  - ASCII constants: ASCII_ZERO=8'h30, ASCII_NINE=8'h39, ASCII_SOH=8'h01.
- One natural sub-module: ascii_dec_accum. It is the combinational digit-classify plus multiply-by-10-add step with the overflow flag, reusable by other numeric-tag decoders. The FSM stays in the top module.

Test Plan:
- start_i with expected=123; bytes "1","2","3",SOH -> result_valid_o at N+2, seq_num_o=123, status SEQ_OK, digits_o=3; ack returns FSM to IDLE.
- expected=100; bytes "1","0","5" with byte_last_i on "5" -> seq_num_o=105, SEQ_GAP. Repeat with "9","9",SOH -> seq_num_o=99, SEQ_LOW.
- Bytes "4294967296",SOH -> SEQ_ERR via overflow; DRAIN consumes through SOH. Bytes "4294967295",SOH with expected 4294967295 -> SEQ_OK.
- Bytes "1","A","2",SOH -> SEQ_ERR, all 4 bytes accepted. SOH as first byte -> SEQ_ERR, digits_o=0.
- Bytes "007",SOH with expected 7 -> SEQ_ERR without SEQ_LEADING_ZERO_EN, SEQ_OK with it.
- Assert rst after 2 digits -> all outputs at reset values immediately. Separately, start_i after 2 digits -> old field discarded; new field "5",SOH -> seq_num_o=5.

Source files
------------

// File: rtl/seq_pkg.sv
// rtl/seq_pkg.sv - shared status codes, FSM states and ASCII constants for the sequence-number checker
package seq_pkg;

    localparam logic [1:0] SEQ_OK  = 2'b00;
    localparam logic [1:0] SEQ_GAP = 2'b01;
    localparam logic [1:0] SEQ_LOW = 2'b10;
    localparam logic [1:0] SEQ_ERR = 2'b11;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_NINE = 8'h39;
    localparam logic [7:0] ASCII_SOH  = 8'h01;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ACCUM   = 3'd1,
        DRAIN   = 3'd2,
        COMPARE = 3'd3,
        RESULT  = 3'd4
    } seq_state_t;

endpackage

// File: rtl/ascii_dec_accum.sv
// rtl/ascii_dec_accum.sv - combinational ASCII digit classify and acc*10+digit step with overflow flag
module ascii_dec_accum
    import seq_pkg::*;
#(
    parameter int BIN_WIDTH  = 32,
    parameter int MAX_DIGITS = 10,
    parameter int DCNT_WIDTH = 4
) (
    input  logic [BIN_WIDTH-1:0]  acc,
    input  logic [DCNT_WIDTH-1:0] count,
    input  logic [7:0]            data,
    output logic                  is_digit,
    output logic                  is_soh,
    output logic                  is_zero,
    output logic [BIN_WIDTH-1:0]  acc_next,
    output logic [DCNT_WIDTH-1:0] count_next,
    output logic                  overflow
);

    logic [BIN_WIDTH+3:0] wide;
    logic [BIN_WIDTH+3:0] acc_wide;

    assign is_digit = (data >= ASCII_ZERO) && (data <= ASCII_NINE);
    assign is_soh   = (data == ASCII_SOH);
    assign is_zero  = (data == ASCII_ZERO);

    // The low nibble of an ASCII digit is its numeric value; 4 spare bits hold acc*10+9
    assign acc_wide   = {4'b0000, acc};
    assign wide       = (acc_wide << 3) + (acc_wide << 1) + {{BIN_WIDTH{1'b0}}, data[3:0]};
    assign acc_next   = wide[BIN_WIDTH-1:0];
    assign count_next = count + DCNT_WIDTH'(1);
    assign overflow   = (wide[BIN_WIDTH+3:BIN_WIDTH] != 4'b0000) ||
                        (count_next > DCNT_WIDTH'(MAX_DIGITS));

endmodule

// File: rtl/seq_num_checker.sv
// rtl/seq_num_checker.sv - MsgSeqNum ASCII-to-binary decode and compare; SEQ_LEADING_ZERO_EN allows leading zeros
module seq_num_checker
    import seq_pkg::*;
#(
    parameter int BIN_WIDTH  = 32,
    parameter int MAX_DIGITS = 10,
    parameter int DCNT_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic [BIN_WIDTH-1:0]  expected_seq_num_i,
    input  logic                  byte_valid_i,
    input  logic [7:0]            byte_i,
    input  logic                  byte_last_i,
    output logic                  byte_ready_o,
    output logic [BIN_WIDTH-1:0]  seq_num_o,
    output logic [1:0]            seq_status_o,
    output logic [DCNT_WIDTH-1:0] digits_o,
    output logic                  result_valid_o,
    input  logic                  result_ack_i
);

    seq_state_t            state, state_next;
    logic [BIN_WIDTH-1:0]  expected, acc, acc_next;
    logic [DCNT_WIDTH-1:0] count, count_next;
    logic                  err;
    logic                  is_digit, is_soh, dig_zero, overflow;
    logic                  accept, clear, take_digit, set_err, load_result, clear_valid;
    logic                  lz_violation;
    logic [1:0]            status;

    ascii_dec_accum #(
        .BIN_WIDTH (BIN_WIDTH),
        .MAX_DIGITS(MAX_DIGITS),
        .DCNT_WIDTH(DCNT_WIDTH)
    ) u_dec (
        .acc       (acc),
        .count     (count),
        .data      (byte_i),
        .is_digit  (is_digit),
        .is_soh    (is_soh),
        .is_zero   (dig_zero),
        .acc_next  (acc_next),
        .count_next(count_next),
        .overflow  (overflow)
    );

    assign byte_ready_o = (state == ACCUM) || (state == DRAIN);
    assign accept       = byte_valid_i && byte_ready_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // start_i takes priority over a byte offered in the same cycle
    always_comb begin
        state_next  = state;
        clear       = 1'b0;
        take_digit  = 1'b0;
        set_err     = 1'b0;
        load_result = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: begin
                if (start_i) begin
                    clear      = 1'b1;
                    state_next = ACCUM;
                end
            end
            ACCUM: begin
                if (start_i) begin
                    clear = 1'b1;
                end else if (accept) begin
                    if (is_digit) begin
                        take_digit = 1'b1;
                        set_err    = overflow;
                        if (byte_last_i)   state_next = COMPARE;
                        else if (overflow) state_next = DRAIN;
                    end else if (is_soh) begin
                        state_next = COMPARE;
                    end else begin
                        set_err    = 1'b1;
                        state_next = byte_last_i ? COMPARE : DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (start_i) begin
                    clear      = 1'b1;
                    state_next = ACCUM;
                end else if (accept && (is_soh || byte_last_i)) begin
                    state_next = COMPARE;
                end
            end
            COMPARE: begin
                load_result = 1'b1;
                state_next  = RESULT;
            end
            RESULT: begin
                if (result_ack_i) begin
                    clear_valid = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

`ifdef SEQ_LEADING_ZERO_EN
    assign lz_violation = 1'b0;
`else
    logic lead_zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)                                               lead_zero <= 1'b0;
        else if (clear)                                        lead_zero <= 1'b0;
        else if (take_digit && (count == '0) && dig_zero)      lead_zero <= 1'b1;
    end

    assign lz_violation = lead_zero && (count > DCNT_WIDTH'(1));
`endif

    always_comb begin
        status = SEQ_LOW;
        if (err || (count == '0) || (acc == '0) || lz_violation) status = SEQ_ERR;
        else if (acc == expected)                                 status = SEQ_OK;
        else if (acc > expected)                                  status = SEQ_GAP;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            expected       <= '0;
            acc            <= '0;
            count          <= '0;
            err            <= 1'b0;
            seq_num_o      <= '0;
            seq_status_o   <= SEQ_OK;
            digits_o       <= '0;
            result_valid_o <= 1'b0;
        end else begin
            if (clear) begin
                expected <= expected_seq_num_i;
                acc      <= '0;
                count    <= '0;
                err      <= 1'b0;
            end else begin
                if (take_digit) begin
                    acc   <= acc_next;
                    count <= count_next;
                end
                if (set_err) err <= 1'b1;
            end
            if (load_result) begin
                seq_num_o      <= acc;
                digits_o       <= count;
                seq_status_o   <= status;
                result_valid_o <= 1'b1;
            end
            if (clear_valid) result_valid_o <= 1'b0;
        end
    end

endmodule
